// File: rtl/peripheral_mpram_tl_adapter.sv
// peripheral_mpram_tl_adapter: TL-UL slave front-end that turns one A-channel request at a time
// into an MPRAM BIU strobe transfer and returns the matching D-channel response.
module peripheral_mpram_tl_adapter #(
    parameter int XLEN    = 64,
    parameter int PLEN    = 64,
    parameter int SRCW    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid_i,
    output logic            a_ready_o,
    input  logic [2:0]      a_opcode_i,
    input  logic [2:0]      a_size_i,
    input  logic [SRCW-1:0] a_source_i,
    input  logic [PLEN-1:0] a_address_i,
    input  logic [XLEN-1:0] a_data_i,
    output logic            d_valid_o,
    input  logic            d_ready_i,
    output logic [2:0]      d_opcode_o,
    output logic [2:0]      d_size_o,
    output logic [SRCW-1:0] d_source_o,
    output logic            d_denied_o,
    output logic [XLEN-1:0] d_data_o,
    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    input  logic            biu_d_ack_i,
    output logic [PLEN-1:0] biu_adri_o,
    input  logic [PLEN-1:0] biu_adro_i,
    output logic [2:0]      biu_size_o,
    output logic [2:0]      biu_type_o,
    output logic [2:0]      biu_prot_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic [XLEN-1:0] biu_q_i,
    input  logic            biu_ack_i,
    input  logic            biu_err_i
);
    typedef enum logic [1:0] {IDLE, STB, WAIT, RESP} state_t;
    localparam logic [2:0] MAX_SIZE = (XLEN == 64) ? 3'd3 : 3'd2;

    state_t          state;
    logic [2:0]      size;
    logic [SRCW-1:0] source;
    logic [PLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            we;
    logic            get;
    logic            denied;
    logic [7:0]      cnt;
    logic [PLEN-1:0] amask;
    logic            ok;
    logic            done;
    logic            unused;

    assign amask = (PLEN'(1) << a_size_i) - PLEN'(1);
    assign ok = (a_opcode_i == 3'd0 || a_opcode_i == 3'd1 || a_opcode_i == 3'd4) &&
                a_size_i <= MAX_SIZE && (a_address_i & amask) == '0;
    assign done = biu_ack_i || biu_err_i;
    assign unused = ^{biu_d_ack_i, biu_adro_i};

    assign a_ready_o  = state == IDLE;
    assign d_valid_o  = state == RESP;
    assign biu_stb_o  = state == STB;
    assign d_opcode_o = {2'b00, get};
    assign d_size_o   = size;
    assign d_source_o = source;
    assign d_denied_o = denied;
    assign d_data_o   = rdata;
    assign biu_adri_o = addr;
    assign biu_size_o = size;
    assign biu_type_o = 3'b000;
    assign biu_prot_o = 3'b000;
    assign biu_lock_o = 1'b0;
    assign biu_we_o   = we;
    assign biu_d_o    = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            size   <= '0;
            source <= '0;
            addr   <= '0;
            wdata  <= '0;
            rdata  <= '0;
            we     <= 1'b0;
            get    <= 1'b0;
            denied <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (a_valid_i) begin
                    size   <= a_size_i;
                    source <= a_source_i;
                    addr   <= a_address_i;
                    wdata  <= a_data_i;
                    we     <= a_opcode_i[2:1] == 2'b00;
                    get    <= a_opcode_i == 3'd4;
                    denied <= !ok;
                    rdata  <= '0;
                    cnt    <= '0;
                    state  <= ok ? STB : RESP;
                end
                // a completion in STB only counts once the strobe itself is accepted
                STB, WAIT: if (done && (state == WAIT || biu_stb_ack_i)) begin
                    denied <= biu_err_i;
                    rdata  <= (biu_err_i || we) ? '0 : biu_q_i;
                    state  <= RESP;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    denied <= 1'b1;
                    state  <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (biu_stb_ack_i) state <= WAIT;
                end
                RESP: if (d_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_peripheral_mpram_tl_adapter.sv
// tb_peripheral_mpram_tl_adapter: directed scenario tests for the TL-UL to MPRAM BIU adapter.
module tb_peripheral_mpram_tl_adapter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid_i = 1'b0;
    logic        a_ready_o;
    logic [2:0]  a_opcode_i = '0;
    logic [2:0]  a_size_i = '0;
    logic [3:0]  a_source_i = '0;
    logic [63:0] a_address_i = '0;
    logic [63:0] a_data_i = '0;
    logic        d_valid_o;
    logic        d_ready_i = 1'b0;
    logic [2:0]  d_opcode_o;
    logic [2:0]  d_size_o;
    logic [3:0]  d_source_o;
    logic        d_denied_o;
    logic [63:0] d_data_o;
    logic        biu_stb_o;
    logic        biu_stb_ack_i = 1'b0;
    logic        biu_d_ack_i = 1'b0;
    logic [63:0] biu_adri_o;
    logic [63:0] biu_adro_i = '0;
    logic [2:0]  biu_size_o;
    logic [2:0]  biu_type_o;
    logic [2:0]  biu_prot_o;
    logic        biu_lock_o;
    logic        biu_we_o;
    logic [63:0] biu_d_o;
    logic [63:0] biu_q_i = '0;
    logic        biu_ack_i = 1'b0;
    logic        biu_err_i = 1'b0;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] WDATA = 64'hDEADBEEF_CAFEF00D;

    always #5 clk = ~clk;

    peripheral_mpram_tl_adapter #(.XLEN(64), .PLEN(64), .SRCW(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
        .a_size_i(a_size_i), .a_source_i(a_source_i), .a_address_i(a_address_i),
        .a_data_i(a_data_i), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
        .d_opcode_o(d_opcode_o), .d_size_o(d_size_o), .d_source_o(d_source_o),
        .d_denied_o(d_denied_o), .d_data_o(d_data_o), .biu_stb_o(biu_stb_o),
        .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i), .biu_adri_o(biu_adri_o),
        .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o), .biu_type_o(biu_type_o),
        .biu_prot_o(biu_prot_o), .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o),
        .biu_d_o(biu_d_o), .biu_q_i(biu_q_i), .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one request while a_ready_o is high; returns one cycle after acceptance
    task automatic accept(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                          input logic [63:0] addr, input logic [63:0] data);
        a_valid_i = 1'b1; a_opcode_i = op; a_size_i = sz; a_source_i = src;
        a_address_i = addr; a_data_i = data;
        step();
        a_valid_i = 1'b0;
    endtask

    task automatic handshake();
        d_ready_i = 1'b1;
        step();
        d_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL rst_a_ready got %b exp 1", a_ready_o); end
        checks++; if (d_valid_o !== 1'b0) begin errors++; $display("FAIL rst_d_valid got %b exp 0", d_valid_o); end
        checks++; if (biu_stb_o !== 1'b0 || biu_we_o !== 1'b0) begin errors++; $display("FAIL rst_biu got stb=%b we=%b exp 0 0", biu_stb_o, biu_we_o); end
        checks++; if ({d_data_o, biu_adri_o, biu_d_o} !== '0 || {d_source_o, d_size_o, d_opcode_o, d_denied_o} !== '0) begin
            errors++; $display("FAIL rst_fields got data=%h adr=%h src=%h exp 0", d_data_o, biu_adri_o, d_source_o); end
        @(negedge clk) rst = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        accept(3'd0, 3'd3, 4'd2, 64'h40, WDATA);
        checks++; if (biu_stb_o !== 1'b1 || biu_we_o !== 1'b1 || a_ready_o !== 1'b0) begin
            errors++; $display("FAIL put_stb got stb=%b we=%b rdy=%b exp 1 1 0", biu_stb_o, biu_we_o, a_ready_o); end
        checks++; if (biu_adri_o !== 64'h40 || biu_d_o !== WDATA || biu_size_o !== 3'd3) begin
            errors++; $display("FAIL put_fields got adr=%h d=%h sz=%0d exp 40 %h 3", biu_adri_o, biu_d_o, biu_size_o, WDATA); end
        checks++; if ({biu_type_o, biu_prot_o, biu_lock_o} !== 7'd0) begin
            errors++; $display("FAIL put_fixed got type=%0d prot=%0d lock=%b exp 0", biu_type_o, biu_prot_o, biu_lock_o); end
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1;
        step();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0;
        checks++; if (d_valid_o !== 1'b1 || d_opcode_o !== 3'd0 || d_denied_o !== 1'b0 || d_source_o !== 4'd2 || d_size_o !== 3'd3) begin
            errors++; $display("FAIL put_resp got v=%b op=%0d den=%b src=%0d sz=%0d exp 1 0 0 2 3", d_valid_o, d_opcode_o, d_denied_o, d_source_o, d_size_o); end
        checks++; if (d_data_o !== 64'd0 || biu_stb_o !== 1'b0) begin
            errors++; $display("FAIL put_resp_data got data=%h stb=%b exp 0 0", d_data_o, biu_stb_o); end
        handshake();
        checks++; if (a_ready_o !== 1'b1 || d_valid_o !== 1'b0) begin
            errors++; $display("FAIL put_idle got rdy=%b v=%b exp 1 0", a_ready_o, d_valid_o); end
        accept(3'd4, 3'd3, 4'd3, 64'h40, 64'd0);
        checks++; if (biu_stb_o !== 1'b1 || biu_we_o !== 1'b0) begin
            errors++; $display("FAIL get_stb got stb=%b we=%b exp 1 0", biu_stb_o, biu_we_o); end
        biu_stb_ack_i = 1'b1;
        step();
        biu_stb_ack_i = 1'b0;
        checks++; if (biu_stb_o !== 1'b0 || d_valid_o !== 1'b0) begin
            errors++; $display("FAIL get_wait got stb=%b v=%b exp 0 0", biu_stb_o, d_valid_o); end
        biu_ack_i = 1'b1; biu_q_i = WDATA;
        step();
        biu_ack_i = 1'b0; biu_q_i = '0;
        checks++; if (d_valid_o !== 1'b1 || d_opcode_o !== 3'd1 || d_denied_o !== 1'b0 || d_source_o !== 4'd3 || d_data_o !== WDATA) begin
            errors++; $display("FAIL get_resp got v=%b op=%0d den=%b src=%0d data=%h exp 1 1 0 3 %h", d_valid_o, d_opcode_o, d_denied_o, d_source_o, d_data_o, WDATA); end
        handshake();
    endtask

    task automatic test_invalid();
        accept(3'd4, 3'd2, 4'd1, 64'h42, 64'd0);
        checks++; if (d_valid_o !== 1'b1 || d_denied_o !== 1'b1 || d_opcode_o !== 3'd1 || biu_stb_o !== 1'b0) begin
            errors++; $display("FAIL misaligned got v=%b den=%b op=%0d stb=%b exp 1 1 1 0", d_valid_o, d_denied_o, d_opcode_o, biu_stb_o); end
        handshake();
        accept(3'd4, 3'd4, 4'd1, 64'h0, 64'd0);
        checks++; if (d_valid_o !== 1'b1 || d_denied_o !== 1'b1 || biu_stb_o !== 1'b0) begin
            errors++; $display("FAIL oversize got v=%b den=%b stb=%b exp 1 1 0", d_valid_o, d_denied_o, biu_stb_o); end
        handshake();
        accept(3'd5, 3'd3, 4'd6, 64'h40, 64'd0);
        checks++; if (d_valid_o !== 1'b1 || d_denied_o !== 1'b1 || biu_stb_o !== 1'b0 || d_source_o !== 4'd6) begin
            errors++; $display("FAIL bad_opcode got v=%b den=%b stb=%b src=%0d exp 1 1 0 6", d_valid_o, d_denied_o, biu_stb_o, d_source_o); end
        handshake();
        accept(3'd1, 3'd2, 4'd7, 64'h44, 64'h1);
        checks++; if (biu_stb_o !== 1'b1 || d_valid_o !== 1'b0) begin
            errors++; $display("FAIL partial_ok got stb=%b v=%b exp 1 0", biu_stb_o, d_valid_o); end
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1;
        step();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0;
        handshake();
    endtask

    task automatic test_error();
        accept(3'd0, 3'd3, 4'd4, 64'h80, 64'h5);
        biu_stb_ack_i = 1'b1; biu_err_i = 1'b1;
        step();
        biu_stb_ack_i = 1'b0; biu_err_i = 1'b0;
        checks++; if (d_valid_o !== 1'b1 || d_denied_o !== 1'b1 || d_opcode_o !== 3'd0) begin
            errors++; $display("FAIL put_err got v=%b den=%b op=%0d exp 1 1 0", d_valid_o, d_denied_o, d_opcode_o); end
        handshake();
        accept(3'd4, 3'd3, 4'd4, 64'h80, 64'd0);
        biu_stb_ack_i = 1'b1;
        step();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b1; biu_err_i = 1'b1; biu_q_i = 64'h1111;
        step();
        biu_ack_i = 1'b0; biu_err_i = 1'b0; biu_q_i = '0;
        checks++; if (d_valid_o !== 1'b1 || d_denied_o !== 1'b1 || d_data_o !== 64'd0 || d_opcode_o !== 3'd1) begin
            errors++; $display("FAIL ack_err got v=%b den=%b data=%h op=%0d exp 1 1 0 1", d_valid_o, d_denied_o, d_data_o, d_opcode_o); end
        handshake();
    endtask

    task automatic test_timeout();
        int n = 0;
        accept(3'd4, 3'd3, 4'd9, 64'h10, 64'd0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (d_valid_o === 1'b1) begin n = i; break; end
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL timeout_cycles got %0d exp 8", n); end
        checks++; if (d_denied_o !== 1'b1 || d_opcode_o !== 3'd1) begin
            errors++; $display("FAIL timeout_resp got den=%b op=%0d exp 1 1", d_denied_o, d_opcode_o); end
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1; biu_q_i = 64'h77;
        step();
        checks++; if (d_valid_o !== 1'b1 || d_denied_o !== 1'b1 || d_data_o !== 64'd0) begin
            errors++; $display("FAIL late_ack_resp got v=%b den=%b data=%h exp 1 1 0", d_valid_o, d_denied_o, d_data_o); end
        handshake();
        step();
        checks++; if (a_ready_o !== 1'b1 || biu_stb_o !== 1'b0 || d_valid_o !== 1'b0) begin
            errors++; $display("FAIL late_ack_idle got rdy=%b stb=%b v=%b exp 1 0 0", a_ready_o, biu_stb_o, d_valid_o); end
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0; biu_q_i = '0;
    endtask

    task automatic test_back_to_back();
        accept(3'd0, 3'd3, 4'd8, 64'h20, 64'h99);
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1;
        step();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0;
        a_valid_i = 1'b1; a_opcode_i = 3'd4; a_size_i = 3'd3; a_source_i = 4'd5; a_address_i = 64'h8;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (d_valid_o !== 1'b1 || a_ready_o !== 1'b0 || d_source_o !== 4'd8 || d_denied_o !== 1'b0 || biu_stb_o !== 1'b0) begin
                errors++; $display("FAIL backpressure[%0d] got v=%b rdy=%b src=%0d den=%b stb=%b exp 1 0 8 0 0", i, d_valid_o, a_ready_o, d_source_o, d_denied_o, biu_stb_o); end
        end
        handshake();
        checks++; if (a_ready_o !== 1'b1 || d_valid_o !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b v=%b exp 1 0", a_ready_o, d_valid_o); end
        step();
        a_valid_i = 1'b0;
        checks++; if (biu_stb_o !== 1'b1 || biu_adri_o !== 64'h8 || biu_we_o !== 1'b0) begin
            errors++; $display("FAIL bp_next got stb=%b adr=%h we=%b exp 1 8 0", biu_stb_o, biu_adri_o, biu_we_o); end
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1; biu_q_i = 64'hABC;
        step();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0; biu_q_i = '0;
        checks++; if (d_data_o !== 64'hABC || d_source_o !== 4'd5) begin
            errors++; $display("FAIL bp_next_resp got data=%h src=%0d exp abc 5", d_data_o, d_source_o); end
        handshake();
    endtask

    task automatic test_reset_mid();
        accept(3'd4, 3'd3, 4'd11, 64'h30, 64'd0);
        biu_stb_ack_i = 1'b1;
        step();
        biu_stb_ack_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (a_ready_o !== 1'b1 || d_valid_o !== 1'b0 || biu_stb_o !== 1'b0 || biu_adri_o !== 64'd0 || d_source_o !== 4'd0 || d_size_o !== 3'd0) begin
            errors++; $display("FAIL mid_reset got rdy=%b v=%b stb=%b adr=%h src=%0d sz=%0d exp 1 0 0 0 0 0", a_ready_o, d_valid_o, biu_stb_o, biu_adri_o, d_source_o, d_size_o); end
        @(negedge clk) rst = 1'b1;
        step();
        accept(3'd4, 3'd3, 4'd12, 64'h38, 64'd0);
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1; biu_q_i = 64'h1234;
        step();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0; biu_q_i = '0;
        checks++; if (d_valid_o !== 1'b1 || d_data_o !== 64'h1234 || d_source_o !== 4'd12 || d_denied_o !== 1'b0) begin
            errors++; $display("FAIL post_reset_get got v=%b data=%h src=%0d den=%b exp 1 1234 12 0", d_valid_o, d_data_o, d_source_o, d_denied_o); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_invalid();
        test_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/peripheral_mpram_tl_adapter.md
# peripheral_mpram_tl_adapter

TileLink-UL slave front-end for the TileLink MPRAM peripheral. Accepts one TL-UL A-channel request at a time, validates it, drives the MPRAM BIU strobe interface, waits for the transfer acknowledge or error, and returns a D-channel response. It sits directly upstream of the MPRAM TileLink top and is its only BIU master.

## Interface
- XLEN, 64, data width in bits (32 or 64)
- PLEN, 64, address width in bits
- SRCW, 4, TL source-ID width
- TIMEOUT, 255, max cycles waiting for biu_ack_i/biu_err_i (8-bit counter; 1..255)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- a_valid_i / a_ready_o  in/out  1  A-channel handshake
- a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get; others unsupported
- a_size_i  in  3  log2(bytes)
- a_source_i  in  SRCW  request ID
- a_address_i  in  PLEN  byte address
- a_data_i  in  XLEN  write data
- d_valid_o / d_ready_i  out/in  1  D-channel handshake
- d_opcode_o  out  3  0=AccessAck, 1=AccessAckData
- d_size_o  out  3  echo of a_size_i
- d_source_o  out  SRCW  echo of a_source_i
- d_denied_o  out  1  request failed
- d_data_o  out  XLEN  read data (0 on writes and errors)
- biu_stb_o  out  1  strobe to MPRAM
- biu_stb_ack_i  in  1  strobe accepted
- biu_d_ack_i  in  1  data acknowledge (ignored)
- biu_adri_o  out  PLEN  address
- biu_adro_i  in  PLEN  returned address (ignored)
- biu_size_o / biu_type_o / biu_prot_o  out  3  size (=a_size), type fixed 3'b000 (single), prot fixed 3'b000
- biu_lock_o  out  1  tied 0
- biu_we_o  out  1  1 for Put
- biu_d_o  out  XLEN  write data
- biu_q_i  in  XLEN  read data
- biu_ack_i / biu_err_i  in  1  transfer done / failed

## Operation
- FSM states: IDLE, STB, WAIT, RESP.
- IDLE: a_ready_o=1. On a_valid_i: latch opcode, size, source, address, data. Check: opcode in {0,1,4}; a_size_i <= log2(XLEN/8); address aligned to 2^a_size_i. Pass -> STB. Fail -> RESP with d_denied_o=1, no BIU activity.
- STB: biu_stb_o=1 with all biu_* outputs stable from latched fields. On biu_stb_ack_i -> WAIT; if biu_ack_i or biu_err_i arrives in the same cycle, complete directly -> RESP.
- WAIT: biu_stb_o=0. On biu_ack_i: capture biu_q_i for Get -> RESP, denied=0. On biu_err_i (priority over ack if both): -> RESP, denied=1, data 0.
- Timeout: 8-bit counter cleared on entry to STB, increments in STB and WAIT; reaching TIMEOUT -> RESP, denied=1. Late BIU acks after timeout are ignored in IDLE/RESP.
- RESP: d_valid_o=1, fields held stable until d_ready_i; d_opcode_o=1 for Get (including denied), 0 for Put. On d_ready_i -> IDLE.
- PutPartialData is treated as full-width of the given size (mask not carried by BIU).

## Timing
- Reset (rst=0, async): state IDLE; a_ready_o=1; d_valid_o, d_denied_o, biu_stb_o, biu_we_o=0; all data/address/size/source/opcode outputs 0; counter 0.
- All outputs registered or decoded from registered state; no combinational path from a_valid_i to biu_stb_o or from biu_ack_i to d_valid_o.
- Minimum latency: accept at cycle N, biu_stb_o high N+1; with stb_ack and ack at N+1, d_valid_o high N+2; with d_ready_i=1, a_ready_o high N+3.
- Invalid request: accept N, d_valid_o N+1.
- Throughput: one outstanding transaction; a_ready_o=0 in STB/WAIT/RESP.
- Reset mid-transaction drops it immediately; no response issued.

## Test plan
- Write then read: Put size 3, addr 0x40, data 0xDEADBEEF_CAFEF00D, src 2 -> biu_we_o=1, AccessAck denied=0 src 2; Get addr 0x40 -> AccessAckData, d_data_o=0xDEADBEEF_CAFEF00D.
- Misaligned Get size 2, addr 0x42 -> d_denied_o=1, d_opcode_o=1, biu_stb_o never asserted; opcode 5 -> same with no BIU strobe.
- biu_err_i on write -> AccessAck, denied=1; biu_ack_i and biu_err_i together -> denied=1.
- TIMEOUT=8, BIU never acks -> d_valid_o with denied=1 exactly 8 cycles after stb entry; a later biu_ack_i ignored.
- D backpressure: d_ready_i low 5 cycles -> d_* stable, a_ready_o=0 throughout, next request accepted cycle after d_ready_i.
- Assert rst=0 while in WAIT -> all outputs at reset values immediately; after release, new Get completes normally.
